data_check: RTL and testbench

- AXI4-Stream sink and pattern checker for the Aurora user RX path.
- Counterpart to the framed incrementing-pattern transmitter: consumes frames, verifies content and framing, accumulates statistics for a VIO/ILA or register readback.
- Each frame is FRAME_LEN beats. Full-width data is 1, 2, … FRAME_LEN (restarts at 1 every frame). tkeep is all ones. tlast is asserted on beat FRAME_LEN only.

---
 rtl/data_check_pkg.sv | 26 ++
 rtl/data_check_sat_counter.sv | 33 +++
 rtl/data_check.sv | 173 +++++++++++++++++
 tb/tb_data_check.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_check_pkg.sv
// Shared types and constants for the data_check stream sink/checker.
package data_check_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRecv  = 2'd1,
    StDrain = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_DATA  = 2'd1;
  localparam logic [1:0] ERR_KEEP  = 2'd2;
  localparam logic [1:0] ERR_FRAME = 2'd3;

  localparam int unsigned DEFAULT_FRAME_LEN = 11;

  // Framing outranks keep, which outranks data, when one beat has several faults.
  function automatic logic [1:0] err_prio(input logic data_err, input logic keep_err,
                                          input logic frame_err);
    if (frame_err) return ERR_FRAME;
    if (keep_err)  return ERR_KEEP;
    if (data_err)  return ERR_DATA;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/data_check_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/data_check.sv
// AXI4-Stream sink that checks framed incrementing-pattern traffic and keeps statistics.
module data_check
  import data_check_pkg::*;
#(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned KEEP_W    = 32,
  parameter int unsigned FRAME_LEN = DEFAULT_FRAME_LEN,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              check_en,
  input  logic              clr_stats,
  input  logic              axis_tvalid,
  output logic              axis_tready,
  input  logic [DATA_W-1:0] axis_tdata,
  input  logic [KEEP_W-1:0] axis_tkeep,
  input  logic              axis_tlast,
  output logic [CNT_W-1:0]  good_frames,
  output logic [CNT_W-1:0]  bad_frames,
  output logic [CNT_W-1:0]  beat_count,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              err_sticky,
  output logic [1:0]        err_code
);

  localparam int unsigned IdxW = $clog2(FRAME_LEN + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_LEN);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              frame_err_q, frame_err_d;
  logic              tready_q, tready_d;
  logic              done_q, done_d;
  logic              ok_q, ok_d;
  logic              sticky_q, sticky_d;
  logic [1:0]        code_q, code_d;

  logic            accept;
  logic            checking;
  logic            close;
  logic            data_err, keep_err, framing_err, beat_err;
  logic            frame_bad;
  logic [IdxW-1:0] beat_num;

  assign accept   = axis_tvalid & tready_q;
  // idx_q counts beats already taken in this frame, so the incoming beat is idx_q + 1.
  assign beat_num = idx_q + IdxW'(1);
  assign data_err = (axis_tdata != exp_q);
  assign keep_err = (axis_tkeep != {KEEP_W{1'b1}});

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    idx_d       = idx_q;
    frame_err_d = frame_err_q;
    code_d      = code_q;
    checking    = 1'b0;
    close       = 1'b0;
    framing_err = 1'b0;

    unique case (state_q)
      StIdle, StRecv: begin
        if (accept) begin
          checking = 1'b1;
          exp_d    = exp_q + DATA_W'(1);
          idx_d    = beat_num;
          if (axis_tlast) begin
            framing_err = (beat_num != LastIdx);
            close       = 1'b1;
            state_d     = StIdle;
          end else if (beat_num == LastIdx) begin
            framing_err = 1'b1;
            state_d     = StDrain;
          end else begin
            state_d = StRecv;
          end
        end
      end
      StDrain: begin
        if (accept && axis_tlast) begin
          close   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    beat_err  = checking & (data_err | keep_err | framing_err);
    frame_bad = frame_err_q | beat_err;

    if (beat_err) begin
      code_d = err_prio(data_err, keep_err, framing_err);
    end

    if (close) begin
      exp_d       = DATA_W'(1);
      idx_d       = '0;
      frame_err_d = 1'b0;
    end else if (beat_err) begin
      frame_err_d = 1'b1;
    end

    done_d   = close;
    ok_d     = close & ~frame_bad;
    sticky_d = clr_stats ? 1'b0 : (sticky_q | beat_err);
    // Once a frame has started it is always drained to completion, whatever check_en does.
    tready_d = (state_d == StIdle) ? check_en : 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      exp_q       <= DATA_W'(1);
      idx_q       <= '0;
      frame_err_q <= 1'b0;
      tready_q    <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      sticky_q    <= 1'b0;
      code_q      <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      idx_q       <= idx_d;
      frame_err_q <= frame_err_d;
      tready_q    <= tready_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      sticky_q    <= sticky_d;
      code_q      <= code_d;
    end
  end

  sat_counter #(
    .Width(CNT_W)
  ) u_good_cnt (
    .aclk   (aclk),
    .aresetn(aresetn),
    .inc_i  (close & ~frame_bad),
    .clr_i  (clr_stats),
    .count_o(good_frames)
  );

  sat_counter #(
    .Width(CNT_W)
  ) u_bad_cnt (
    .aclk   (aclk),
    .aresetn(aresetn),
    .inc_i  (close & frame_bad),
    .clr_i  (clr_stats),
    .count_o(bad_frames)
  );

  sat_counter #(
    .Width(CNT_W)
  ) u_beat_cnt (
    .aclk   (aclk),
    .aresetn(aresetn),
    .inc_i  (accept),
    .clr_i  (clr_stats),
    .count_o(beat_count)
  );

  assign axis_tready = tready_q;
  assign frame_done  = done_q;
  assign frame_ok    = ok_q;
  assign err_sticky  = sticky_q;
  assign err_code    = code_q;

endmodule

// File: tb/tb_data_check.sv
// Directed bench for data_check: frame-level reference model plus literal spot checks.
module tb_data_check;

  localparam int unsigned DW = 256;
  localparam int unsigned KW = 32;
  localparam int unsigned FL = 11;
  localparam int unsigned CW = 8;
  localparam int CntMax = (1 << CW) - 1;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          check_en = 1'b0;
  logic          clr_stats = 1'b0;
  logic          axis_tvalid = 1'b0;
  logic          axis_tready;
  logic [DW-1:0] axis_tdata = '0;
  logic [KW-1:0] axis_tkeep = '0;
  logic          axis_tlast = 1'b0;
  logic [CW-1:0] good_frames, bad_frames, beat_count;
  logic          frame_done, frame_ok, err_sticky;
  logic [1:0]    err_code;

  data_check #(
    .DATA_W   (DW),
    .KEEP_W   (KW),
    .FRAME_LEN(FL),
    .CNT_W    (CW)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .check_en   (check_en),
    .clr_stats  (clr_stats),
    .axis_tvalid(axis_tvalid),
    .axis_tready(axis_tready),
    .axis_tdata (axis_tdata),
    .axis_tkeep (axis_tkeep),
    .axis_tlast (axis_tlast),
    .good_frames(good_frames),
    .bad_frames (bad_frames),
    .beat_count (beat_count),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .err_sticky (err_sticky),
    .err_code   (err_code)
  );

  always #5 aclk = ~aclk;

  // Reference model: tracks the frame as a beat count plus error/drain flags.
  int       m_n, m_good, m_bad, m_beats;
  bit       m_ferr, m_drain, m_sticky, m_done, m_ok, m_tready;
  bit [1:0] m_code;

  function automatic int sat(input int v);
    return (v < CntMax) ? v + 1 : v;
  endfunction

  always @(posedge aclk) begin
    automatic int       n_l = m_n;
    automatic int       good_l = m_good;
    automatic int       bad_l = m_bad;
    automatic int       beats_l = m_beats;
    automatic bit       ferr_l = m_ferr;
    automatic bit       drain_l = m_drain;
    automatic bit       sticky_l = m_sticky;
    automatic bit [1:0] code_l = m_code;
    automatic bit       close_l = 1'b0;
    automatic bit       err_l = 1'b0;
    automatic bit       de, ke, fe;
    if (!aresetn) begin
      n_l = 0; good_l = 0; bad_l = 0; beats_l = 0; ferr_l = 0; drain_l = 0;
      sticky_l = 0; code_l = 2'd0;
      m_tready <= 1'b0;
    end else begin
      if (axis_tvalid && axis_tready) begin
        beats_l = sat(beats_l);
        n_l++;
        if (!drain_l) begin
          de = (axis_tdata != DW'(n_l));
          ke = (axis_tkeep != {KW{1'b1}});
          fe = axis_tlast ? (n_l != int'(FL)) : (n_l == int'(FL));
          err_l = de | ke | fe;
          if (fe) code_l = 2'd3;
          else if (ke) code_l = 2'd2;
          else if (de) code_l = 2'd1;
          if (err_l) begin
            ferr_l = 1'b1;
            sticky_l = 1'b1;
          end
          if (axis_tlast) close_l = 1'b1;
          else if (n_l == int'(FL)) drain_l = 1'b1;
        end else if (axis_tlast) begin
          close_l = 1'b1;
        end
      end
      if (close_l) begin
        if (ferr_l) bad_l = sat(bad_l);
        else good_l = sat(good_l);
      end
      if (clr_stats) begin
        good_l = 0; bad_l = 0; beats_l = 0; sticky_l = 0;
      end
      m_done <= close_l;
      m_ok   <= close_l & ~ferr_l;
      if (close_l) begin
        n_l = 0; ferr_l = 0; drain_l = 0;
      end
      m_tready <= (n_l > 0) ? 1'b1 : check_en;
    end
    if (!aresetn) begin
      m_done <= 1'b0;
      m_ok   <= 1'b0;
    end
    m_n <= n_l; m_good <= good_l; m_bad <= bad_l; m_beats <= beats_l;
    m_ferr <= ferr_l; m_drain <= drain_l; m_sticky <= sticky_l; m_code <= code_l;
  end

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int ok_seen = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge aclk);
      if (cmp_en) begin
        check("tready", axis_tready, m_tready);
        check("good_frames", good_frames, m_good);
        check("bad_frames", bad_frames, m_bad);
        check("beat_count", beat_count, m_beats);
        check("frame_done", frame_done, m_done);
        check("frame_ok", frame_ok, m_ok);
        check("err_sticky", err_sticky, m_sticky);
        check("err_code", err_code, m_code);
        if (frame_done === 1'b1) done_seen++;
        if (frame_done === 1'b1 && frame_ok === 1'b1) ok_seen++;
      end
    end
  endtask

  task automatic idle(input int n);
    axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    axis_tvalid = 1'b0;
    clr_stats = 1'b0;
    repeat (2) begin
      @(posedge aclk);
      #1;
    end
    aresetn = 1'b1;
    idle(2);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input logic clr);
    automatic bit got = 1'b0;
    axis_tvalid = 1'b1;
    axis_tdata  = d;
    axis_tkeep  = k;
    axis_tlast  = l;
    clr_stats   = clr;
    for (int g = 0; g < 64 && !got; g++) begin
      @(negedge aclk);
      if (axis_tready === 1'b1) got = 1'b1;
      @(posedge aclk);
      #1;
    end
    if (!got) check("accept_timeout", 64'(got), 64'd1);
    axis_tvalid = 1'b0;
    axis_tlast  = 1'b0;
    clr_stats   = 1'b0;
  endtask

  task automatic send_frame(input int nbeats, input int last_at, input int bad_idx,
                            input int bad_val, input int bad_keep_idx, input bit rnd,
                            input int drop_at, input int clr_at);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    for (int i = 1; i <= nbeats; i++) begin
      if (rnd) idle($urandom_range(0, 2));
      if (i == drop_at) check_en = 1'b0;
      d = (i == bad_idx) ? DW'(bad_val) : DW'(i);
      k = (i == bad_keep_idx) ? KW'(32'hFFFF_FFFE) : {KW{1'b1}};
      send_beat(d, k, (i == last_at), (i == clr_at));
    end
  endtask

  task automatic clean_frame();
    send_frame(FL, FL, 0, 0, 0, 1'b0, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, o0;
    fork
      compare_loop();
    join_none

    // Clean traffic
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    cmp_en = 1'b1;
    check("reset_tready", axis_tready, 0);
    check("reset_good", good_frames, 0);
    check("reset_code", err_code, 0);
    check_en = 1'b1;
    do_reset();
    d0 = done_seen; o0 = ok_seen;
    repeat (3) clean_frame();
    idle(3);
    check("t1_good", good_frames, 3);
    check("t1_bad", bad_frames, 0);
    check("t1_beats", beat_count, 33);
    check("t1_done_pulses", done_seen - d0, 3);
    check("t1_ok_pulses", ok_seen - o0, 3);
    check("t1_sticky", err_sticky, 0);

    // Data error on beat 5
    do_reset();
    send_frame(FL, FL, 5, 7, 0, 1'b0, 0, 0);
    idle(3);
    check("t2_bad", bad_frames, 1);
    check("t2_code", err_code, 1);
    check("t2_sticky", err_sticky, 1);
    clean_frame();
    idle(3);
    check("t2_good", good_frames, 1);

    // Early tlast
    do_reset();
    send_frame(8, 8, 0, 0, 0, 1'b0, 0, 0);
    idle(3);
    check("t3_bad", bad_frames, 1);
    check("t3_code", err_code, 3);
    check("t3_beats", beat_count, 8);
    clean_frame();
    idle(3);
    check("t3_good", good_frames, 1);

    // Overlong frame drained
    do_reset();
    d0 = done_seen;
    send_frame(14, 14, 0, 0, 0, 1'b0, 0, 0);
    idle(3);
    check("t4_bad", bad_frames, 1);
    check("t4_good", good_frames, 0);
    check("t4_beats", beat_count, 14);
    check("t4_done_pulses", done_seen - d0, 1);
    check("t4_code", err_code, 3);

    // Gappy tvalid, check_en dropped mid-frame
    do_reset();
    send_frame(FL, FL, 0, 0, 0, 1'b1, 4, 0);
    idle(3);
    check("t5_good", good_frames, 1);
    check("t5_bad", bad_frames, 0);
    check("t5_tready_off", axis_tready, 0);
    check_en = 1'b1;

    // clr_stats coincident with frame close, then reset mid-frame
    do_reset();
    send_frame(FL, FL, 3, 99, 0, 1'b0, 0, 0);
    send_frame(FL, FL, 0, 0, 0, 1'b0, 0, FL);
    idle(3);
    check("t6_good", good_frames, 0);
    check("t6_bad", bad_frames, 0);
    check("t6_beats", beat_count, 0);
    check("t6_sticky", err_sticky, 0);
    send_frame(5, 0, 0, 0, 0, 1'b0, 0, 0);
    do_reset();
    clean_frame();
    idle(3);
    check("t6_good_after_rst", good_frames, 1);
    check("t6_bad_after_rst", bad_frames, 0);
    check("t6_beats_after_rst", beat_count, 11);

    // Keep error and counter saturation
    do_reset();
    send_frame(FL, FL, 0, 0, 2, 1'b0, 0, 0);
    idle(3);
    check("t7_keep_code", err_code, 2);
    repeat (24) clean_frame();
    idle(3);
    check("t7_beats_sat", beat_count, 255);
    check("t7_good", good_frames, 24);
    check("t7_bad", bad_frames, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
